// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one bit per clock.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       functcode,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned DW = 2 * WIDTH;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t state_q, state_d;

  logic [DW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Request decode
  logic             op_mul, op_div, op_sgn, op_dz;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    op_mul = (functcode == F_MULT) || (functcode == F_MULTU);
    op_div = (functcode == F_DIV)  || (functcode == F_DIVU);
    op_sgn = (functcode == F_MULT) || (functcode == F_DIV);
    op_dz  = op_div && (rt_content == '0);
    abs_a  = (op_sgn && rs_content[WIDTH-1]) ? (~rs_content + WIDTH'(1)) : rs_content;
    abs_b  = (op_sgn && rt_content[WIDTH-1]) ? (~rt_content + WIDTH'(1)) : rt_content;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start && (op_mul || op_div)) state_d = op_dz ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and HI/LO update
  logic [WIDTH:0]   mul_sum, div_rem, div_diff;
  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    acc_d     = acc_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : WIDTH'(0))};
    div_rem  = acc_q[DW-1:WIDTH-1];
    div_diff = div_rem - {1'b0, opb_q};
    prod     = neg_res_q ? (~acc_q + DW'(1)) : acc_q;
    quo      = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem      = neg_rem_q ? (~acc_q[DW-1:WIDTH] + WIDTH'(1)) : acc_q[DW-1:WIDTH];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (functcode == F_MTHI) hi_d = rs_content;
          if (functcode == F_MTLO) lo_d = rs_content;
          if (op_mul || op_div) begin
            acc_d     = {WIDTH'(0), abs_a};
            opb_d     = abs_b;
            cnt_d     = CNT_W'(WIDTH - 1);
            is_div_d  = op_div;
            dz_d      = op_dz;
            neg_res_d = op_sgn && (rs_content[WIDTH-1] ^ rt_content[WIDTH-1]);
            neg_rem_d = op_sgn && rs_content[WIDTH-1];
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (!is_div_q)
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else if (!div_diff[WIDTH])
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
          acc_d = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
      S_FIX: begin
        done_d = 1'b1;
        if (!dz_q) begin
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[DW-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
